// File: rtl/dat_sram_pkg.sv
// Shared types and constants for the dat_* data-memory responder.
// The range predicate lives here so the top and any checker agree on it.
package dat_sram_pkg;

  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } state_e;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  // True when any address bit above the word index is set.
  function automatic logic out_of_range(input logic [15:0] addr, input int aw);
    return (addr >> (aw + 2)) != 16'd0;
  endfunction

endpackage

// File: rtl/dat_sram_lane.sv
// One byte lane of the data memory: single write port, asynchronous read port.
// No reset on the array; the top zero-fills it after reset instead.
module dat_sram_lane
  import dat_sram_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [LANE_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [LANE_W-1:0] rdata_o
);

  logic [LANE_W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dat_sram.sv
// Memory-side responder for the core's dat_* port: registered request capture,
// byte-lane writes, write-first byte-lane reads with per-lane hold, zero-fill on reset.
module dat_sram
  import dat_sram_pkg::*;
#(
  parameter int AW   = 8,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     dat_a,
  input  logic [3:0]      dat_we,
  input  logic [31:0]     dat_wd,
  input  logic [3:0]      dat_re,
  output logic [31:0]     dat_rd,
  output logic            init_busy,
  output logic [ERRW-1:0] err_cnt
);

  state_e          state_q;
  logic [AW-1:0]   clr_idx_q;
  logic            busy_q;

  logic [AW-1:0]   a_q,   a_d;
  logic [3:0]      we_q,  we_d;
  logic [31:0]     wd_q,  wd_d;
  logic [3:0]      re_q,  re_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [31:0]     hold_q;

  logic            req_oor;
  logic            req_any;
  logic            unused_addr_bits;

  assign req_oor          = out_of_range(dat_a, AW);
  assign req_any          = (|dat_we) | (|dat_re);
  assign unused_addr_bits = ^dat_a[1:0];

  // Fill sequencer: one word per cycle, handing over to RUN on the last index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == {AW{1'b1}}) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= CLR;
        end
      endcase
    end
  end

  always_comb begin
    a_d   = a_q;
    wd_d  = wd_q;
    we_d  = '0;
    re_d  = '0;
    err_d = err_q;
    if (state_q == RUN) begin
      a_d  = dat_a[AW+1:2];
      wd_d = dat_wd;
      if (!req_oor) begin
        we_d = dat_we;
        re_d = dat_re;
      end else if (req_any && (err_q != {ERRW{1'b1}})) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      we_q   <= '0;
      wd_q   <= '0;
      re_q   <= '0;
      err_q  <= '0;
      hold_q <= '0;
    end else begin
      a_q    <= a_d;
      we_q   <= we_d;
      wd_q   <= wd_d;
      re_q   <= re_d;
      err_q  <= err_d;
      hold_q <= dat_rd;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic              lane_we;
      logic [AW-1:0]     lane_waddr;
      logic [LANE_W-1:0] lane_wdata;
      logic [LANE_W-1:0] lane_rdata;

      // The fill owns the write port while in CLR; we_q is zero there anyway.
      assign lane_we    = (state_q == CLR) | we_q[gi];
      assign lane_waddr = (state_q == CLR) ? clr_idx_q : a_q;
      assign lane_wdata = (state_q == CLR) ? '0 : wd_q[gi*LANE_W +: LANE_W];

      dat_sram_lane #(
        .AW(AW)
      ) u_lane (
        .clk    (clk),
        .we_i   (lane_we),
        .waddr_i(lane_waddr),
        .wdata_i(lane_wdata),
        .raddr_i(a_q),
        .rdata_o(lane_rdata)
      );

      assign dat_rd[gi*LANE_W +: LANE_W] =
        !re_q[gi] ? hold_q[gi*LANE_W +: LANE_W] :
        we_q[gi]  ? wd_q[gi*LANE_W +: LANE_W]   :
                    lane_rdata;
    end
  endgenerate

  assign init_busy = busy_q;
  assign err_cnt   = err_q;

endmodule
